// File: rtl/symm_rsqrt_scale.sv
// Row normaliser: bit-serial square root of each row sum, then restoring division of every element by its row norm.
// Optional macro SYMM_RSQRT_SAT_EN: saturate out-of-range quotients and report ovf (default: wrap, ovf tied 0).
module symm_rsqrt_scale #(
  parameter int W    = 26,
  parameter int FRAC = 22
) (
  input  logic                clk_rsqrt,
  input  logic                rstn_rsqrt,
  input  logic                en_rsqrt,
  input  logic signed [W-1:0] i11, i12, i13, i14,
  input  logic signed [W-1:0] i21, i22, i23, i24,
  input  logic signed [W-1:0] i31, i32, i33, i34,
  input  logic signed [W-1:0] i41, i42, i43, i44,
  input  logic signed [W-1:0] sum1, sum2, sum3, sum4,
  output logic signed [W-1:0] o11, o12, o13, o14,
  output logic signed [W-1:0] o21, o22, o23, o24,
  output logic signed [W-1:0] o31, o32, o33, o34,
  output logic signed [W-1:0] o41, o42, o43, o44,
  output logic                busy,
  output logic                done,
  output logic [3:0]          zero_flag,
  output logic                ovf
);

  localparam int SR = 2 * W + 2;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_SQRT, S_DIV, S_DONE} state_t;

  state_t              state;
  logic signed [W-1:0] x_in    [16];
  logic signed [W-1:0] sum_in  [4];
  logic signed [W-1:0] x_reg   [16];
  logic signed [W-1:0] sum_reg [4];
  logic        [W-1:0] root_reg[4];
  logic signed [W-1:0] res_buf [16];
  logic signed [W-1:0] res_nx  [16];
  logic signed [W-1:0] o_reg   [16];
  logic [3:0]          zf_buf;
  logic                ovf_buf;
  logic [CW-1:0]       bit_cnt;
  logic [1:0]          row_cnt;
  logic [3:0]          elem_cnt;

  // Square-root iteration state
  logic [SR-1:0]  s_rem, s_rem_cur, s_rem_sh, s_trial, s_rem_nx;
  logic [W-1:0]   s_root, s_root_cur, s_root_nx;
  logic [2*W-1:0] s_rad, s_rad_cur, s_rad_nx, rad_init;
  logic           s_pos, s_ge;

  // Division iteration state
  logic [SR-1:0]  d_rem, d_rem_cur, d_rem_nx, r_ext, rem1, rem1r, rem2;
  logic [2*W-1:0] d_dvd, d_dvd_cur, d_dvd_nx, dvd_init;
  logic [W:0]     d_acc, d_acc_cur, d_acc_nx;
  logic           d_stk, d_stk_cur, d_stk_nx, qb1, qb2, neg;
  logic [W-1:0]   d_root, ax, q_mag;
  logic signed [W-1:0] q_val;
  logic           q_ovf, ovf_nx, first, last_bit;

  assign x_in   = '{i11, i12, i13, i14, i21, i22, i23, i24,
                    i31, i32, i33, i34, i41, i42, i43, i44};
  assign sum_in = '{sum1, sum2, sum3, sum4};

  assign o11 = o_reg[0];  assign o12 = o_reg[1];  assign o13 = o_reg[2];  assign o14 = o_reg[3];
  assign o21 = o_reg[4];  assign o22 = o_reg[5];  assign o23 = o_reg[6];  assign o24 = o_reg[7];
  assign o31 = o_reg[8];  assign o32 = o_reg[9];  assign o33 = o_reg[10]; assign o34 = o_reg[11];
  assign o41 = o_reg[12]; assign o42 = o_reg[13]; assign o43 = o_reg[14]; assign o44 = o_reg[15];

  assign first    = (bit_cnt == '0);
  assign last_bit = (bit_cnt == CW'(W - 1));

  // The first cycle of each row/element works on freshly loaded operands instead of the registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    rad_init   = '0;
    s_pos      = !sum_reg[row_cnt][W-1] && (sum_reg[row_cnt] != '0);
    if (s_pos) rad_init = {{(W - FRAC){1'b0}}, sum_reg[row_cnt], {FRAC{1'b0}}};
    s_rad_cur  = first ? rad_init : s_rad;
    s_rem_cur  = first ? '0 : s_rem;
    s_root_cur = first ? '0 : s_root;
    s_rem_sh   = {s_rem_cur[SR-3:0], s_rad_cur[2*W-1 -: 2]};
    s_trial    = {{(SR - W - 2){1'b0}}, s_root_cur, 2'b01};
    s_ge       = (s_rem_sh >= s_trial);
    s_rem_nx   = s_ge ? s_rem_sh - s_trial : s_rem_sh;
    s_root_nx  = {s_root_cur[W-2:0], s_ge};
    s_rad_nx   = {s_rad_cur[2*W-3:0], 2'b00};
  end

  // Two restoring steps per cycle so the full 2W-bit dividend is consumed in W cycles;
  // quotient bits pushed out of the accumulator fold into a sticky overflow bit.
  always_comb begin
    d_root    = root_reg[elem_cnt[3:2]];
    neg       = x_reg[elem_cnt][W-1];
    ax        = neg ? W'(-x_reg[elem_cnt]) : x_reg[elem_cnt];
    dvd_init  = {{(W - FRAC){1'b0}}, ax, {FRAC{1'b0}}};
    d_dvd_cur = first ? dvd_init : d_dvd;
    d_rem_cur = first ? '0 : d_rem;
    d_acc_cur = first ? '0 : d_acc;
    d_stk_cur = first ? 1'b0 : d_stk;
    r_ext     = {{(SR - W){1'b0}}, d_root};
    rem1      = {d_rem_cur[SR-2:0], d_dvd_cur[2*W-1]};
    qb1       = (d_root != '0) && (rem1 >= r_ext);
    rem1r     = qb1 ? rem1 - r_ext : rem1;
    rem2      = {rem1r[SR-2:0], d_dvd_cur[2*W-2]};
    qb2       = (d_root != '0) && (rem2 >= r_ext);
    d_rem_nx  = qb2 ? rem2 - r_ext : rem2;
    d_acc_nx  = {d_acc_cur[W-2:0], qb1, qb2};
    d_stk_nx  = d_stk_cur | d_acc_cur[W] | d_acc_cur[W-1];
    d_dvd_nx  = {d_dvd_cur[2*W-3:0], 2'b00};
    q_mag     = d_acc_nx[W-1:0];
    q_ovf     = 1'b0;
    q_val     = '0;
`ifdef SYMM_RSQRT_SAT_EN
    if (d_root != '0) begin
      if (d_stk_nx | d_acc_nx[W] | d_acc_nx[W-1]) begin
        q_ovf = 1'b1;
        q_val = neg ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
      end else begin
        q_val = neg ? -q_mag : q_mag;
      end
    end
`else
    if (d_root != '0) q_val = neg ? -q_mag : q_mag;
`endif
    res_nx           = res_buf;
    res_nx[elem_cnt] = q_val;
    ovf_nx           = ovf_buf | q_ovf;
  end

  always_ff @(posedge clk_rsqrt or negedge rstn_rsqrt) begin
    if (!rstn_rsqrt) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      zero_flag <= '0;
      ovf       <= 1'b0;
      zf_buf    <= '0;
      ovf_buf   <= 1'b0;
      bit_cnt   <= '0;
      row_cnt   <= '0;
      elem_cnt  <= '0;
      s_rem     <= '0;
      s_root    <= '0;
      s_rad     <= '0;
      d_rem     <= '0;
      d_dvd     <= '0;
      d_acc     <= '0;
      d_stk     <= 1'b0;
      // NOTE: these arrays are small register banks, not RAM, so resetting them is cheap and keeps aborted runs invisible.
      for (int i = 0; i < 16; i++) begin
        x_reg[i]   <= '0;
        res_buf[i] <= '0;
        o_reg[i]   <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        sum_reg[i]  <= '0;
        root_reg[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (en_rsqrt) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            x_reg    <= x_in;
            sum_reg  <= sum_in;
            bit_cnt  <= '0;
            row_cnt  <= '0;
            elem_cnt <= '0;
            zf_buf   <= '0;
            ovf_buf  <= 1'b0;
            busy     <= 1'b1;
            state    <= S_SQRT;
          end
        end
        S_SQRT: begin
          s_rem  <= s_rem_nx;
          s_root <= s_root_nx;
          s_rad  <= s_rad_nx;
          if (first) zf_buf[row_cnt] <= ~s_pos;
          if (last_bit) begin
            root_reg[row_cnt] <= s_root_nx;
            bit_cnt           <= '0;
            row_cnt           <= row_cnt + 2'd1;
            if (row_cnt == 2'd3) state <= S_DIV;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        S_DIV: begin
          d_rem <= d_rem_nx;
          d_dvd <= d_dvd_nx;
          d_acc <= d_acc_nx;
          d_stk <= d_stk_nx;
          if (last_bit) begin
            res_buf  <= res_nx;
            ovf_buf  <= ovf_nx;
            bit_cnt  <= '0;
            elem_cnt <= elem_cnt + 4'd1;
            if (elem_cnt == 4'd15) begin
              o_reg     <= res_nx;
              zero_flag <= zf_buf;
              ovf       <= ovf_nx;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_symm_rsqrt_scale.sv
// Self-checking bench for symm_rsqrt_scale: directed and random runs against an integer reference model.
module tb_symm_rsqrt_scale;
  localparam int W    = 26;
  localparam int FRAC = 22;
  localparam int LAT  = 20 * W;
  localparam longint MAXP = (64'sd1 <<< (W - 1)) - 1;

  logic clk_rsqrt = 1'b0;
  logic rstn_rsqrt = 1'b0;
  logic en_rsqrt = 1'b0;
  logic signed [W-1:0] x_in [16];
  logic signed [W-1:0] s_in [4];
  logic signed [W-1:0] o_w  [16];
  logic busy, done, ovf;
  logic [3:0] zero_flag;

  int checks = 0;
  int errors = 0;
  longint e_out [16];
  logic [3:0] e_zf;
  logic e_ovf;
  int lat, nd;

  always #5 clk_rsqrt = ~clk_rsqrt;

  symm_rsqrt_scale #(.W(W), .FRAC(FRAC)) dut (
    .clk_rsqrt(clk_rsqrt), .rstn_rsqrt(rstn_rsqrt), .en_rsqrt(en_rsqrt),
    .i11(x_in[0]),  .i12(x_in[1]),  .i13(x_in[2]),  .i14(x_in[3]),
    .i21(x_in[4]),  .i22(x_in[5]),  .i23(x_in[6]),  .i24(x_in[7]),
    .i31(x_in[8]),  .i32(x_in[9]),  .i33(x_in[10]), .i34(x_in[11]),
    .i41(x_in[12]), .i42(x_in[13]), .i43(x_in[14]), .i44(x_in[15]),
    .sum1(s_in[0]), .sum2(s_in[1]), .sum3(s_in[2]), .sum4(s_in[3]),
    .o11(o_w[0]),  .o12(o_w[1]),  .o13(o_w[2]),  .o14(o_w[3]),
    .o21(o_w[4]),  .o22(o_w[5]),  .o23(o_w[6]),  .o24(o_w[7]),
    .o31(o_w[8]),  .o32(o_w[9]),  .o33(o_w[10]), .o34(o_w[11]),
    .o41(o_w[12]), .o42(o_w[13]), .o43(o_w[14]), .o44(o_w[15]),
    .busy(busy), .done(done), .zero_flag(zero_flag), .ovf(ovf)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint isqrt(input longint n);
    longint lo = 0, hi = 64'sd1 <<< 24, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // Reference: norm = floor(sqrt(sum * 2^FRAC)), out = sign(x) * floor(|x| * 2^FRAC / norm), then range mapping.
  task automatic model();
    longint r [4];
    longint x, ax, q, v;
    e_zf  = '0;
    e_ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (longint'(s_in[k]) <= 0) begin
        r[k] = 0;
        e_zf[k] = 1'b1;
      end else begin
        r[k] = isqrt(longint'(s_in[k]) * (64'sd1 <<< FRAC));
      end
    end
    for (int e = 0; e < 16; e++) begin
      x = longint'(x_in[e]);
      if (r[e / 4] == 0) begin
        e_out[e] = 0;
      end else begin
        ax = (x < 0) ? -x : x;
        q  = (ax * (64'sd1 <<< FRAC)) / r[e / 4];
        v  = (x < 0) ? -q : q;
`ifdef SYMM_RSQRT_SAT_EN
        if (q > MAXP) begin
          e_ovf = 1'b1;
          v = (x < 0) ? -(MAXP + 1) : MAXP;
        end
`else
        v = v % (64'sd1 <<< W);
        if (v < 0) v += (64'sd1 <<< W);
        if (v > MAXP) v -= (64'sd1 <<< W);
`endif
        e_out[e] = v;
      end
    end
  endtask

  task automatic rand_inputs();
    longint acc;
    int kind;
    for (int e = 0; e < 16; e++)
      x_in[e] = W'(int'($urandom_range(0, 10485760)) - 5242880);
    for (int k = 0; k < 4; k++) begin
      kind = int'($urandom_range(0, 3));
      acc = 0;
      for (int j = 0; j < 4; j++) acc += longint'(x_in[4*k+j]) * longint'(x_in[4*k+j]);
      case (kind)
        0: s_in[k] = W'(acc >>> FRAC);
        1: s_in[k] = W'(-int'($urandom_range(0, 1000)));
        2: s_in[k] = W'($urandom_range(1, 255));
        default: s_in[k] = W'($urandom_range(1, 33554431));
      endcase
    end
  endtask

  task automatic check_outputs(input string pre);
    for (int e = 0; e < 16; e++)
      check($sformatf("%s_o%0d%0d", pre, e / 4 + 1, e % 4 + 1), o_w[e], e_out[e]);
    check({pre, "_zero_flag"}, zero_flag, e_zf);
    check({pre, "_ovf"}, ovf, e_ovf);
  endtask

  // One start pulse, then a fixed window of cycles; optional extra start or mid-run reset.
  task automatic run(input int en_at, input int rst_at, output int lat_o, output int nd_o);
    lat_o = 0;
    nd_o  = 0;
    @(negedge clk_rsqrt) en_rsqrt = 1'b1;
    @(posedge clk_rsqrt);
    #1 check("busy_after_start", busy, 1);
    for (int c = 1; c <= LAT + 40; c++) begin
      @(negedge clk_rsqrt);
      en_rsqrt   = (c == en_at);
      rstn_rsqrt = (c != rst_at);
      if (c == en_at) rand_inputs();
      if (c == rst_at) begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_o11", o_w[0], 0);
        check("rst_o44", o_w[15], 0);
        check("rst_zero_flag", zero_flag, 0);
      end
      @(posedge clk_rsqrt);
      #1;
      if (done) begin
        nd_o++;
        if (lat_o == 0) lat_o = c;
      end
      if (rst_at < 0 && c == LAT) check("busy_at_done", busy, 1);
      if (rst_at < 0 && c == LAT + 1) check("busy_after_done", busy, 0);
    end
    en_rsqrt = 1'b0;
  endtask

  initial begin
    for (int e = 0; e < 16; e++) x_in[e] = '0;
    for (int k = 0; k < 4; k++) s_in[k] = '0;
    repeat (3) @(posedge clk_rsqrt);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_zero_flag", zero_flag, 0);
    check("reset_ovf", ovf, 0);
    check("reset_o11", o_w[0], 0);
    check("reset_o44", o_w[15], 0);
    @(negedge clk_rsqrt) rstn_rsqrt = 1'b1;
    repeat (2) @(posedge clk_rsqrt);

    // Directed matrix covering unit row, signed row, zero-sum row and tiny-sum row.
    for (int j = 0; j < 4; j++) x_in[j] = 26'sd4194304;
    x_in[4] = -26'sd8388608; x_in[5] = '0; x_in[6] = '0; x_in[7] = '0;
    x_in[8] = 26'sd1000000; x_in[9] = -26'sd77; x_in[10] = 26'sd4194304; x_in[11] = 26'sd3;
    x_in[12] = 26'sd4194304; x_in[13] = '0; x_in[14] = '0; x_in[15] = '0;
    s_in[0] = 26'sd16777216; s_in[1] = 26'sd16777216; s_in[2] = '0; s_in[3] = 26'sd1;
    model();
    run(-1, -1, lat, nd);
    check("dir_latency", lat, LAT);
    check("dir_done_count", nd, 1);
    check_outputs("dir");
    for (int j = 0; j < 4; j++) check($sformatf("dir_row1_half_%0d", j), o_w[j], 2097152);
    check("dir_o21_neg_one", o_w[4], -4194304);
    check("dir_o22_zero", o_w[5], 0);
    check("dir_o31_zero", o_w[8], 0);
    check("dir_zf_row3", zero_flag, 4'b0100);
`ifdef SYMM_RSQRT_SAT_EN
    check("dir_o41_sat", o_w[12], 33554431);
    check("dir_ovf_sat", ovf, 1);
`else
    check("dir_o41_wrap", o_w[12], 0);
    check("dir_ovf_wrap", ovf, 0);
`endif

    // Second start during a run must be ignored; inputs are scrambled at the same moment.
    rand_inputs();
    model();
    run(50, -1, lat, nd);
    check("restart_latency", lat, LAT);
    check("restart_done_count", nd, 1);
    check_outputs("restart");

    // Mid-run reset aborts without a done, then a fresh run completes.
    rand_inputs();
    model();
    run(-1, 200, lat, nd);
    check("abort_done_count", nd, 0);
    check("abort_busy", busy, 0);
    rand_inputs();
    model();
    run(-1, -1, lat, nd);
    check("fresh_latency", lat, LAT);
    check("fresh_done_count", nd, 1);
    check_outputs("fresh");

    for (int t = 0; t < 4; t++) begin
      rand_inputs();
      model();
      run(-1, -1, lat, nd);
      check($sformatf("rand%0d_latency", t), lat, LAT);
      check($sformatf("rand%0d_done_count", t), nd, 1);
      check_outputs($sformatf("rand%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
